vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VIS, 1280: visible pixels per line.
REQ-002 SHALL have parameter H_FP, 48: horizontal front porch, pixels.
REQ-003 SHALL have parameter H_SYNC, 112: hsync width, pixels.
REQ-004 SHALL have parameter H_BP, 248: horizontal back porch, pixels.
REQ-005 SHALL have parameter V_VIS, 1024: visible lines per frame.
REQ-006 SHALL have parameter V_FP, 1: vertical front porch, lines.
REQ-007 SHALL have parameter V_SYNC, 3: vsync width, lines.
REQ-008 SHALL have parameter V_BP, 38: vertical back porch, lines.
REQ-009 SHALL have parameter HS_POL, 1: hsync active level; 1 is active-high.
REQ-010 SHALL have parameter VS_POL, 1: vsync active level; 1 is active-high.
REQ-011 SHALL have port VGA_CLK, input, 1: pixel clock, 108 MHz for the defaults; single clock domain.
REQ-012 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-013 SHALL have port x, output, 11: pixel column, valid while disp_en=1.
REQ-014 SHALL have port y, output, 11: pixel row, valid while disp_en=1.
REQ-015 SHALL have port disp_en, output, 1: pixel is in the visible area.
REQ-016 SHALL have port hsync, output, 1: horizontal sync at HS_POL level.
REQ-017 SHALL have port vsync, output, 1: vertical sync at VS_POL level.
REQ-018 SHALL have port line_start, output, 1: one-cycle pulse on the first pixel of every line.
REQ-019 SHALL have port frame_start, output, 1: one-cycle pulse on pixel (0,0) of every frame.

Function
REQ-020 SHALL compute H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP (default 1688) and V_TOTAL=V_VIS+V_FP+V_SYNC+V_BP (default 1066); both SHALL be at most 2047.
REQ-021 SHALL hold an 11-bit h_cnt that increments every cycle and wraps from H_TOTAL-1 to 0.
REQ-022 SHALL hold an 11-bit v_cnt that increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0 on the same edge as the h_cnt wrap.
REQ-023 SHALL register every output from the current (pre-increment) counter values, giving a fixed latency of 1 cycle with all outputs mutually aligned.
REQ-024 SHALL drive disp_en=1 iff h_cnt<H_VIS and v_cnt<V_VIS.
REQ-025 SHALL drive x=h_cnt and y=v_cnt when disp_en=1, and x=0, y=0 otherwise.
REQ-026 SHALL drive hsync at HS_POL iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC, and at ~HS_POL otherwise.
REQ-027 SHALL drive vsync at VS_POL iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC, for whole lines, and at ~VS_POL otherwise.
REQ-028 SHALL drive line_start=1 iff h_cnt=0, and frame_start=1 iff h_cnt=0 and v_cnt=0.
REQ-029 SHALL track a per-axis phase state VIS->FP->SYNC->BP->VIS, advancing at each region boundary; the region decodes in REQ-024 to REQ-027 SHALL be consistent with that phase.

Reset
REQ-030 SHALL, on any VGA_CLK edge with rst_n=0, set h_cnt=0, v_cnt=0, both phase states to VIS, x=0, y=0, disp_en=0, line_start=0, frame_start=0, hsync=~HS_POL and vsync=~VS_POL, including when reset arrives mid-frame.
REQ-031 SHALL, on the first edge after rst_n rises, output the (0,0) pixel: disp_en=1, line_start=1, frame_start=1.

Structure
REQ-032 SHALL take its default timing constants and the H_TOTAL/V_TOTAL derivation from shared package vga_timing_pkg, which the pixel-colour generators also use.
REQ-033 SHALL implement each axis with one sub-module, vga_axis_cnt, instantiated twice; the module SHALL take a count enable, produce a wrap pulse and phase, and be parameterised by VIS/FP/SYNC/BP.

Verification
REQ-034 SHALL check: rst_n=0 for 5 cycles, then release -> during reset disp_en=0 and hsync=vsync=0; on the first edge after release x=0, y=0, disp_en=1, frame_start=1.
REQ-035 SHALL check, for each line -> line_start period exactly 1688 cycles; disp_en high for 1280 consecutive cycles; hsync high for 112 cycles starting 1328 cycles after line_start.
REQ-036 SHALL check, for each frame -> frame_start period 1799408 cycles; vsync high for 3 full lines starting at line index 1025; disp_en never high with y>=1024.
REQ-037 SHALL check the wrap at (h=1687, v=1065) -> next output is x=0, y=0, frame_start=1; no extra or missed frame_start.
REQ-038 SHALL check rst_n=0 asserted for one cycle at (h=700, v=500) -> outputs take reset values on the next edge, then restart at (0,0) with frame_start=1.
REQ-039 SHALL check overrides H_VIS=8, H_FP=2, H_SYNC=3, H_BP=1, V_VIS=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=0, VS_POL=0 -> line period 14 cycles, frame period 98 cycles, active-low sync widths 3 cycles and 14 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase type and total-size helper for the timing
// generator and the pixel-colour generators.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    localparam int DEF_H_VIS  = 1280;
    localparam int DEF_H_FP   = 48;
    localparam int DEF_H_SYNC = 112;
    localparam int DEF_H_BP   = 248;
    localparam int DEF_V_VIS  = 1024;
    localparam int DEF_V_FP   = 1;
    localparam int DEF_V_SYNC = 3;
    localparam int DEF_V_BP   = 38;

    typedef enum logic [1:0] {
        PH_VIS,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Video timing bundle: pixel position, display enable, syncs and start pulses.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             disp_en;
    logic             hsync;
    logic             vsync;
    logic             line_start;
    logic             frame_start;

    modport master (
        output x, y, disp_en, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input x, y, disp_en, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter plus a VIS->FP->SYNC->BP phase
// state that always describes the region the current count lies in.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int VIS  = DEF_H_VIS,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output phase_t           phase
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(axis_total(VIS, FP, SYNC, BP) - 1);
    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(VIS);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VIS + FP);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(VIS + FP + SYNC);

    logic [CNT_W-1:0] cnt_next;

    assign wrap     = en && (cnt == LAST);
    assign cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;

    // Phase moves on the same edge as the count that enters the next region.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= PH_VIS;
        end else if (en) begin
            cnt <= cnt_next;
            case (phase)
                PH_VIS:  if (cnt_next == FP_START)   phase <= PH_FP;
                PH_FP:   if (cnt_next == SYNC_START) phase <= PH_SYNC;
                PH_SYNC: if (cnt_next == BP_START)   phase <= PH_BP;
                PH_BP:   if (cnt_next == '0)         phase <= PH_VIS;
                default:                             phase <= PH_VIS;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: horizontal and vertical axis counters with all outputs
// registered from the current counts (one cycle latency, mutually aligned).
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic          VGA_CLK,
    input  logic          rst_n,
    vga_timing_if.master  vga
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             vis;
    logic             first_line;

    logic [CNT_W-1:0] x_p1;
    logic [CNT_W-1:0] y_p1;
    logic             disp_en_p1;
    logic             hsync_p1;
    logic             vsync_p1;
    logic             line_start_p1;
    logic             frame_start_p1;

    vga_axis_cnt #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) h_axis (
        .clk   (VGA_CLK),
        .rst_n (rst_n),
        .en    (1'b1),
        .cnt   (h_cnt),
        .wrap  (h_wrap),
        .phase (h_phase)
    );

    vga_axis_cnt #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) v_axis (
        .clk   (VGA_CLK),
        .rst_n (rst_n),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap),
        .phase (v_phase)
    );

    assign vis = (h_phase == PH_VIS) && (v_phase == PH_VIS);

    // Stage p1: registered outputs decoded from the pre-increment counts.
    // first_line marks v_cnt==0 so frame_start follows the vertical wrap.
    always_ff @(posedge VGA_CLK) begin
        if (!rst_n) begin
            x_p1           <= '0;
            y_p1           <= '0;
            disp_en_p1     <= 1'b0;
            hsync_p1       <= ~HS_POL;
            vsync_p1       <= ~VS_POL;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            first_line     <= 1'b1;
        end else begin
            x_p1           <= vis ? h_cnt : '0;
            y_p1           <= vis ? v_cnt : '0;
            disp_en_p1     <= vis;
            hsync_p1       <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_p1       <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            line_start_p1  <= (h_cnt == '0);
            frame_start_p1 <= (h_cnt == '0) && first_line;
            if (h_wrap) begin
                first_line <= v_wrap;
            end
        end
    end

    assign vga.x           = x_p1;
    assign vga.y           = y_p1;
    assign vga.disp_en     = disp_en_p1;
    assign vga.hsync       = hsync_p1;
    assign vga.vsync       = vsync_p1;
    assign vga.line_start  = line_start_p1;
    assign vga.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance and a small override instance,
// both compared every cycle with an arithmetic position model plus directed measurements.
module tb_vga_timing;
    import vga_timing_pkg::*;

    localparam int S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 1;
    localparam int S_VV = 4, S_VFP = 1, S_VS = 1, S_VBP = 1;
    localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
    localparam int S_FT = S_HT * (S_VV + S_VFP + S_VS + S_VBP);

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst_d_n = 1'b0;
    logic rst_s_n = 1'b0;
    int   t_d = -1;
    int   t_s = -1;
    int   tests = 0;
    int   failed = 0;

    vga_timing_if bus_d ();
    vga_timing_if bus_s ();

    vga_timing dut_d (
        .VGA_CLK (clk),
        .rst_n   (rst_d_n),
        .vga     (bus_d)
    );

    vga_timing #(
        .H_VIS (S_HV), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_VIS (S_VV), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut_s (
        .VGA_CLK (clk),
        .rst_n   (rst_s_n),
        .vga     (bus_s)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // t = cycles since the first edge after reset release (-1 while in reset).
    function automatic pix_t model(input int t, input int hv, input int hfp, input int hsw,
                                   input int hbp, input int vv, input int vfp, input int vsw,
                                   input int vbp, input logic hp, input logic vp);
        pix_t e;
        int ht, vt, p, h, v;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        if (t < 0) begin
            e = '{x: 11'd0, y: 11'd0, de: 1'b0, hs: ~hp, vs: ~vp, ls: 1'b0, fs: 1'b0};
            return e;
        end
        p = t % (ht * vt);
        h = p % ht;
        v = p / ht;
        e.de = (h < hv) && (v < vv);
        e.x  = e.de ? 11'(h) : 11'd0;
        e.y  = e.de ? 11'(v) : 11'd0;
        e.hs = (h >= hv + hfp && h < hv + hfp + hsw) ? hp : ~hp;
        e.vs = (v >= vv + vfp && v < vv + vfp + vsw) ? vp : ~vp;
        e.ls = (h == 0);
        e.fs = (p == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int t, input pix_t obs, input pix_t exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s t=%0d: observed x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                   tag, t, obs.x, obs.y, obs.de, obs.hs, obs.vs, obs.ls, obs.fs,
                   exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    // Advance one clock and compare both instances against the model.
    task automatic tick();
        pix_t od, os;
        @(posedge clk);
        t_d = rst_d_n ? t_d + 1 : -1;
        t_s = rst_s_n ? t_s + 1 : -1;
        @(negedge clk);
        od = {bus_d.x, bus_d.y, bus_d.disp_en, bus_d.hsync, bus_d.vsync, bus_d.line_start, bus_d.frame_start};
        os = {bus_s.x, bus_s.y, bus_s.disp_en, bus_s.hsync, bus_s.vsync, bus_s.line_start, bus_s.frame_start};
        chk_pix("def_pix", t_d, od, model(t_d, DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                                          DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, 1'b1, 1'b1));
        chk_pix("small_pix", t_s, os, model(t_s, S_HV, S_HFP, S_HS, S_HBP,
                                            S_VV, S_VFP, S_VS, S_VBP, 1'b0, 1'b0));
    endtask

    task automatic measure_line_def();
        int n, period, de_n, de_last, hs_first, hs_n;
        logic de_gap;
        n = 0;
        while (bus_d.line_start !== 1'b1 && n < 2 * DEF_H_TOTAL) begin
            tick();
            n++;
        end
        chk("def_line_found", 32'(bus_d.line_start), 32'd1);
        period = 0; de_n = 0; de_last = -1; hs_first = -1; hs_n = 0; de_gap = 1'b0;
        do begin
            if (bus_d.disp_en === 1'b1) begin
                if (de_last != period - 1) de_gap = 1'b1;
                de_n++;
                de_last = period;
            end
            if (bus_d.hsync === 1'b1) begin
                if (hs_first < 0) hs_first = period;
                hs_n++;
            end
            tick();
            period++;
        end while (bus_d.line_start !== 1'b1 && period < 2 * DEF_H_TOTAL);
        chk("def_line_period", 32'(period), 32'd1688);
        chk("def_de_len", 32'(de_n), 32'd1280);
        chk("def_de_gap", 32'(de_gap), 32'd0);
        chk("def_hs_start", 32'(hs_first), 32'd1328);
        chk("def_hs_len", 32'(hs_n), 32'd112);
    endtask

    task automatic measure_frame_small();
        int n, period, ls_n, fs_n, hs_first, hs_n, vs_first, vs_n;
        logic ls_bad, de_bad;
        n = 0;
        while (bus_s.frame_start !== 1'b1 && n < 3 * S_FT) begin
            tick();
            n++;
        end
        chk("small_frame_found", 32'(bus_s.frame_start), 32'd1);
        period = 0; ls_n = 0; fs_n = 0; hs_first = -1; hs_n = 0; vs_first = -1; vs_n = 0;
        ls_bad = 1'b0; de_bad = 1'b0;
        do begin
            if (bus_s.line_start === 1'b1) begin
                if (period != ls_n * S_HT) ls_bad = 1'b1;
                ls_n++;
            end
            if (bus_s.frame_start === 1'b1) fs_n++;
            if (period < S_HT && bus_s.hsync === 1'b0) begin
                if (hs_first < 0) hs_first = period;
                hs_n++;
            end
            if (bus_s.vsync === 1'b0) begin
                if (vs_first < 0) vs_first = period;
                vs_n++;
            end
            if (bus_s.disp_en === 1'b1 && bus_s.y >= 11'(S_VV)) de_bad = 1'b1;
            tick();
            period++;
        end while (bus_s.frame_start !== 1'b1 && period < 3 * S_FT);
        chk("small_frame_period", 32'(period), 32'd98);
        chk("small_lines", 32'(ls_n), 32'd7);
        chk("small_line_period", 32'(ls_bad), 32'd0);
        chk("small_fs_count", 32'(fs_n), 32'd1);
        chk("small_hs_start", 32'(hs_first), 32'd10);
        chk("small_hs_len", 32'(hs_n), 32'd3);
        chk("small_vs_start", 32'(vs_first), 32'd70);
        chk("small_vs_len", 32'(vs_n), 32'd14);
        chk("small_de_y_range", 32'(de_bad), 32'd0);
    endtask

    initial begin
        int k, d, n;

        // Reset held for five cycles.
        repeat (5) tick();
        chk("rst_def_de", 32'(bus_d.disp_en), 32'd0);
        chk("rst_def_hs", 32'(bus_d.hsync), 32'd0);
        chk("rst_def_vs", 32'(bus_d.vsync), 32'd0);
        chk("rst_small_hs", 32'(bus_s.hsync), 32'd1);

        // First edge after release shows pixel (0,0).
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;
        tick();
        chk("rel_def_x", 32'(bus_d.x), 32'd0);
        chk("rel_def_y", 32'(bus_d.y), 32'd0);
        chk("rel_def_de", 32'(bus_d.disp_en), 32'd1);
        chk("rel_def_fs", 32'(bus_d.frame_start), 32'd1);
        chk("rel_def_ls", 32'(bus_d.line_start), 32'd1);
        chk("rel_small_fs", 32'(bus_s.frame_start), 32'd1);

        repeat (3) measure_line_def();
        repeat (2) measure_frame_small();

        // Frame wrap on the small instance.
        n = 0;
        while (t_s % S_FT != S_FT - 1 && n < 2 * S_FT) begin
            tick();
            n++;
        end
        chk("wrap_found", 32'(t_s % S_FT), 32'(S_FT - 1));
        tick();
        chk("wrap_x", 32'(bus_s.x), 32'd0);
        chk("wrap_y", 32'(bus_s.y), 32'd0);
        chk("wrap_fs", 32'(bus_s.frame_start), 32'd1);

        // Random mid-frame resets on the small instance.
        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(200, 1));
            d = int'($urandom_range(3, 1));
            repeat (k) tick();
            rst_s_n = 1'b0;
            tick();
            chk("mid_rst_de", 32'(bus_s.disp_en), 32'd0);
            chk("mid_rst_fs", 32'(bus_s.frame_start), 32'd0);
            chk("mid_rst_vs", 32'(bus_s.vsync), 32'd1);
            repeat (d - 1) tick();
            rst_s_n = 1'b1;
            tick();
            chk("mid_restart_fs", 32'(bus_s.frame_start), 32'd1);
            chk("mid_restart_xy", 32'({bus_s.x, bus_s.y}), 32'd0);
        end

        // One-cycle reset on the default instance while its h counter is at 700.
        n = 0;
        while (t_d % DEF_H_TOTAL != 699 && n < 2 * DEF_H_TOTAL) begin
            tick();
            n++;
        end
        chk("h700_found", 32'(t_d % DEF_H_TOTAL), 32'd699);
        rst_d_n = 1'b0;
        tick();
        chk("h700_rst_de", 32'(bus_d.disp_en), 32'd0);
        chk("h700_rst_x", 32'(bus_d.x), 32'd0);
        chk("h700_rst_ls", 32'(bus_d.line_start), 32'd0);
        rst_d_n = 1'b1;
        tick();
        chk("h700_restart_fs", 32'(bus_d.frame_start), 32'd1);
        chk("h700_restart_de", 32'(bus_d.disp_en), 32'd1);

        k = int'($urandom_range(300, 50));
        repeat (k) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
